cart_rom_fetch: RTL and testbench

CART_ROM_FETCH -- requirements
Module: cart_rom_fetch

---
 rtl/cart_rom_fetch.sv | 113 +++++++++++
 tb/tb_cart_rom_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: byte-wide cart ROM reader in front of a 16-bit SDRAM port.
// It keeps a one-word cache so that the second byte of a word costs no SDRAM trip.
// Ports:
//   clk_sys, reset    system clock and synchronous active-high reset
//   rd_stb            one-cycle read strobe; rom_address is valid with it
//   rom_address[24:0] byte address from the cart mapper
//   inval             level; drops the cached word (cart load, flag change)
//   sdr_req, sdr_addr level request and word address to the SDRAM arbiter
//   sdr_ack, sdr_data one-cycle fill pulse and its 16-bit word (low byte = even addr)
//   rom_din[7:0]      byte returned to the mapper; holds between accesses
//   busy              high while an SDRAM request is outstanding
//   timeout_err       sticky; set when a request got no ack within 256 cycles
module cart_rom_fetch (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rd_stb,
  input  logic [24:0] rom_address,
  input  logic        inval,
  output logic        sdr_req,
  output logic [23:0] sdr_addr,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_data,
  output logic [7:0]  rom_din,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [23:0] tag;
  logic [15:0] data;
  logic        valid;
  logic [24:0] lat_addr;
  logic        pend;
  logic [24:0] pend_addr;
  logic [7:0]  cnt;

  // In IDLE a fresh strobe wins over a parked one; otherwise the parked
  // address is replayed as if it had just been strobed.
  logic        req_v;
  logic [24:0] req_a;
  logic        hit;

  always_comb begin
    req_v = rd_stb | pend;
    req_a = rd_stb ? rom_address : pend_addr;
    hit   = valid && (tag == req_a[24:1]);
  end

  assign busy = (state == BUSY);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      tag         <= '0;
      data        <= '0;
      valid       <= 1'b0;
      lat_addr    <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      cnt         <= '0;
      sdr_req     <= 1'b0;
      sdr_addr    <= '0;
      rom_din     <= 8'hFF;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (req_v) begin
            if (hit) begin
              rom_din <= req_a[0] ? data[15:8] : data[7:0];
            end else begin
              lat_addr <= req_a;
              sdr_req  <= 1'b1;
              sdr_addr <= req_a[24:1];
              cnt      <= '0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          // Strobes during a fill park here; the latest one wins.
          if (rd_stb) begin
            pend      <= 1'b1;
            pend_addr <= rom_address;
          end
          if (sdr_ack) begin
            data    <= sdr_data;
            tag     <= lat_addr[24:1];
            valid   <= 1'b1;
            rom_din <= lat_addr[0] ? sdr_data[15:8] : sdr_data[7:0];
            sdr_req <= 1'b0;
            state   <= IDLE;
          end else if (cnt == 8'hFF) begin
            // Give up: cache untouched, mapper sees open-bus 0xFF.
            sdr_req     <= 1'b0;
            rom_din     <= 8'hFF;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so it overrides a same-cycle fill.
      if (inval) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_rom_fetch.sv
module tb_cart_rom_fetch;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        rd_stb;
  logic [24:0] rom_address;
  logic        inval;
  logic        sdr_req;
  logic [23:0] sdr_addr;
  logic        sdr_ack;
  logic [15:0] sdr_data;
  logic [7:0]  rom_din;
  logic        busy;
  logic        timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  cart_rom_fetch dut (
    .clk_sys(clk_sys), .reset(reset), .rd_stb(rd_stb), .rom_address(rom_address),
    .inval(inval), .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_ack(sdr_ack),
    .sdr_data(sdr_data), .rom_din(rom_din), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  // One active edge, then settle: inputs set before this are consumed by that edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a);
    rd_stb = 1'b1; rom_address = a;
    tick();
    rd_stb = 1'b0;
  endtask

  task automatic ack(input logic [15:0] d);
    sdr_ack = 1'b1; sdr_data = d;
    tick();
    sdr_ack = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; rd_stb = 1'b0; rom_address = '0; inval = 1'b0;
    sdr_ack = 1'b0; sdr_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_req",  sdr_req, 0);
    chk("rst_addr", sdr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din",  rom_din, 8'hFF);
    chk("rst_terr", timeout_err, 0);

    // Miss then hit
    strobe(25'h000101);
    chk("miss_req",  sdr_req, 1);
    chk("miss_addr", sdr_addr, 24'h000080);
    chk("miss_busy", busy, 1);
    tick(); tick();
    chk("miss_hold", sdr_req, 1);
    ack(16'hA55A);
    chk("fill_odd",  rom_din, 8'hA5);
    chk("fill_req",  sdr_req, 0);
    chk("fill_busy", busy, 0);
    strobe(25'h000100);
    chk("hit_even", rom_din, 8'h5A);
    chk("hit_req",  sdr_req, 0);
    strobe(25'h000101);
    chk("hit_odd",  rom_din, 8'hA5);
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (sdr_req) n++; end
    chk("hit_noreq", n, 0);
    chk("hit_hold",  rom_din, 8'hA5);

    // Pending, latest wins
    strobe(25'h10);
    chk("pend_addr0", sdr_addr, 24'h08);
    strobe(25'h20);
    strobe(25'h30);
    chk("pend_stable", sdr_addr, 24'h08);
    ack(16'h1234);
    chk("pend_fill", rom_din, 8'h34);
    chk("pend_drop", sdr_req, 0);
    tick();
    chk("pend_req",  sdr_req, 1);
    chk("pend_addr", sdr_addr, 24'h18);
    ack(16'hBEEF);
    chk("pend_fill2", rom_din, 8'hEF);
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (sdr_req) n++; end
    chk("pend_once", n, 0);

    // Strobe coincident with ack checks against the just-filled word
    strobe(25'h50);
    rd_stb = 1'b1; rom_address = 25'h51;
    ack(16'hC3D4);
    rd_stb = 1'b0;
    chk("coin_fill", rom_din, 8'hD4);
    tick();
    chk("coin_hit",  rom_din, 8'hC3);
    chk("coin_req",  sdr_req, 0);
    strobe(25'h30);
    tick();
    chk("coin_refill_req", sdr_req, 1);
    ack(16'hBEEF);

    // Timeout
    strobe(25'h200);
    n = 0;
    while (sdr_req && n < 400) begin n++; tick(); end
    chk("to_len",  n, 256);
    chk("to_din",  rom_din, 8'hFF);
    chk("to_terr", timeout_err, 1);
    chk("to_busy", busy, 0);
    ack(16'h1111);
    chk("late_din",  rom_din, 8'hFF);
    chk("late_busy", busy, 0);
    chk("late_req",  sdr_req, 0);
    strobe(25'h31);
    chk("to_cache", rom_din, 8'hBE);
    chk("to_cache_req", sdr_req, 0);
    chk("to_sticky", timeout_err, 1);

    // Invalidate
    strobe(25'h40);
    ack(16'h7788);
    chk("inv_fill", rom_din, 8'h88);
    strobe(25'h40);
    chk("inv_prehit", sdr_req, 0);
    inval = 1'b1; tick(); inval = 1'b0;
    strobe(25'h41);
    chk("inv_miss", sdr_req, 1);
    chk("inv_addr", sdr_addr, 24'h20);
    inval = 1'b1;
    ack(16'h99AA);
    inval = 1'b0;
    chk("inv_ack_din", rom_din, 8'h99);
    strobe(25'h40);
    chk("inv_ack_miss", sdr_req, 1);
    ack(16'h5566);
    chk("inv_refill", rom_din, 8'h66);

    // Reset mid-BUSY
    strobe(25'h80);
    chk("rb_req", sdr_req, 1);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rb_req0",  sdr_req, 0);
    chk("rb_addr0", sdr_addr, 0);
    chk("rb_din",   rom_din, 8'hFF);
    chk("rb_busy",  busy, 0);
    chk("rb_terr",  timeout_err, 0);
    ack(16'h1234);
    chk("rb_ack_din",  rom_din, 8'hFF);
    chk("rb_ack_busy", busy, 0);
    // Reset beats a same-cycle strobe
    reset = 1'b1; strobe(25'h40); reset = 1'b0;
    chk("rst_prio", sdr_req, 0);
    // Cache was dropped by reset
    strobe(25'h40);
    chk("rst_inval", sdr_req, 1);
    ack(16'h0102);
    chk("rst_refill", rom_din, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
